// File: rtl/spi_dma_wc_mch.sv
// Multi-channel burst write-DMA controller: per-channel address/count/RUN state,
// round-robin selection of one FIFO-backed burst at a time toward the BIU.
module spi_dma_wc_mch #(
    parameter int NCH = 4,
    parameter int AL  = 2,
    parameter int AW  = 32,
    parameter int BL  = 4,
    parameter int FW  = 6,
    parameter int LW  = 16,
    parameter int BND = 12,
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CW-1:0]         pio_ch,
    input  logic                  pio_adr_we,
    input  logic                  pio_len_we,
    input  logic [31:0]           pio_d,
    output logic [31:0]           pio_adr,
    output logic [31:0]           pio_len,
    output logic [31:0]           pio_cst,
    input  logic [NCH*(FW+1)-1:0] dff_cnt,
    input  logic [NCH-1:0]        dff_rval,
    output logic [NCH-1:0]        done,
    output logic [AW-1:0]         biu_adr,
    output logic [BL:0]           biu_len,
    output logic [CW-1:0]         biu_ch,
    output logic                  biu_req,
    input  logic                  biu_ack
);

    typedef enum logic {IDLE, REQ} state_t;

    state_t          state;
    logic [AW-1:0]   adr_q [NCH];
    logic [LW-1:0]   len_q [NCH];
    logic [NCH-1:0]  run_q;
    logic [CW-1:0]   rr_q;

    logic [BL:0]     blen [NCH];
    logic [NCH-1:0]  elig;
    logic            found;
    logic [CW-1:0]   sel;
    logic            pio_ok;
    logic            pio_wr_ok;

    logic unused_pio_bits;
    assign unused_pio_bits = ^pio_d;

    // Burst is clipped by MAXB, the remaining count and the distance to the next boundary.
    function automatic logic [BL:0] calc_blen(input logic [AW-1:0] a, input logic [LW-1:0] l);
        logic [32:0] lim;
        logic [32:0] bw;
        lim = 33'(2**BL);
        if (33'(l) < lim)
            lim = 33'(l);
        bw = ((33'(1) << BND) - 33'(a[BND-1:0])) >> AL;
        if (bw < lim)
            lim = bw;
        return lim[BL:0];
    endfunction

    always_comb begin
        elig = '0;
        for (int i = 0; i < NCH; i++) begin
            blen[i] = calc_blen(adr_q[i], len_q[i]);
            elig[i] = run_q[i] & dff_rval[i] &
                      (dff_cnt[i*(FW+1) +: FW+1] >= (FW+1)'(blen[i]));
        end
    end

    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < NCH; k++) begin
            if (!found && elig[(int'(rr_q) + k) % NCH]) begin
                found = 1'b1;
                sel   = CW'((int'(rr_q) + k) % NCH);
            end
        end
    end

    // The channel owning the outstanding request is frozen against PIO writes.
    assign pio_ok    = (32'(pio_ch) < NCH);
    assign pio_wr_ok = pio_ok && !((state == REQ) && (pio_ch == biu_ch));

    always_comb begin
        pio_adr = '0;
        pio_len = '0;
        pio_cst = '0;
        if (pio_ok) begin
            pio_adr              = 32'(adr_q[pio_ch]);
            pio_len              = 32'(len_q[pio_ch]);
            pio_cst[0]           = run_q[pio_ch];
            pio_cst[1]           = (state == REQ) && (biu_ch == pio_ch);
            pio_cst[16 +: FW+1]  = dff_cnt[int'(pio_ch)*(FW+1) +: FW+1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            run_q   <= '0;
            rr_q    <= '0;
            done    <= '0;
            biu_req <= 1'b0;
            biu_adr <= '0;
            biu_len <= '0;
            biu_ch  <= '0;
            for (int i = 0; i < NCH; i++) begin
                adr_q[i] <= '0;
                len_q[i] <= '0;
            end
        end else begin
            done <= '0;
            if (pio_wr_ok && pio_adr_we)
                adr_q[pio_ch] <= {pio_d[AW-1:AL], {AL{1'b0}}};
            if (pio_wr_ok && pio_len_we) begin
                len_q[pio_ch] <= pio_d[LW-1:0];
                run_q[pio_ch] <= (pio_d[LW-1:0] != '0);
            end
            case (state)
                IDLE: begin
                    if (found) begin
                        biu_ch  <= sel;
                        biu_adr <= adr_q[sel];
                        biu_len <= blen[sel];
                        biu_req <= 1'b1;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (biu_ack) begin
                        biu_req        <= 1'b0;
                        adr_q[biu_ch]  <= adr_q[biu_ch] + (AW'(biu_len) << AL);
                        len_q[biu_ch]  <= len_q[biu_ch] - LW'(biu_len);
                        rr_q           <= (biu_ch == CW'(NCH-1)) ? '0 : biu_ch + CW'(1);
                        if (len_q[biu_ch] == LW'(biu_len)) begin
                            run_q[biu_ch] <= 1'b0;
                            done[biu_ch]  <= 1'b1;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_dma_wc_mch.sv
// Directed bench for spi_dma_wc_mch: table of single-burst sizing cases plus
// hand-written multi-burst, arbitration, PIO-blocking and reset sequences.
module tb_spi_dma_wc_mch;

    localparam int NCH = 4;
    localparam int FW  = 6;
    localparam int CW  = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [CW-1:0]         pio_ch;
    logic                  pio_adr_we;
    logic                  pio_len_we;
    logic [31:0]           pio_d;
    logic [31:0]           pio_adr;
    logic [31:0]           pio_len;
    logic [31:0]           pio_cst;
    logic [NCH*(FW+1)-1:0] dff_cnt;
    logic [NCH-1:0]        dff_rval;
    logic [NCH-1:0]        done;
    logic [31:0]           biu_adr;
    logic [4:0]            biu_len;
    logic [CW-1:0]         biu_ch;
    logic                  biu_req;
    logic                  biu_ack;

    logic [FW:0]           cnt [NCH];
    int                    total = 0;
    int                    bad = 0;

    always #5 clk = ~clk;

    always_comb begin
        dff_cnt = '0;
        for (int i = 0; i < NCH; i++)
            dff_cnt[i*(FW+1) +: FW+1] = cnt[i];
    end

    spi_dma_wc_mch dut (
        .clk(clk), .rst_n(rst_n), .pio_ch(pio_ch), .pio_adr_we(pio_adr_we),
        .pio_len_we(pio_len_we), .pio_d(pio_d), .pio_adr(pio_adr), .pio_len(pio_len),
        .pio_cst(pio_cst), .dff_cnt(dff_cnt), .dff_rval(dff_rval), .done(done),
        .biu_adr(biu_adr), .biu_len(biu_len), .biu_ch(biu_ch), .biu_req(biu_req),
        .biu_ack(biu_ack)
    );

    typedef struct {
        logic [31:0] adr;
        logic [15:0] len;
        logic [6:0]  cnt;
        logic [4:0]  blen;
        logic [31:0] nadr;
        logic [15:0] nlen;
        logic        dn;
    } vec_t;

    vec_t vecs [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int ch, input logic [31:0] adr, input logic [31:0] len);
        pio_ch     = CW'(ch);
        pio_d      = adr;
        pio_adr_we = 1'b1;
        tick();
        pio_adr_we = 1'b0;
        pio_d      = len;
        pio_len_we = 1'b1;
        tick();
        pio_len_we = 1'b0;
    endtask

    task automatic waitReq(input string name);
        int n = 0;
        while (!biu_req && n < 50) begin
            tick();
            n++;
        end
        checkOutput({name, "_req"}, 32'(biu_req), 32'd1);
    endtask

    task automatic ackBurst(input logic [NCH-1:0] clr_rval);
        biu_ack  = 1'b1;
        dff_rval = dff_rval & ~clr_rval;
        tick();
        biu_ack  = 1'b0;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int dcount;
        int ch;
        logic [31:0] base;

        vecs[0] = '{32'h0000_1000, 16'd40,  7'd64, 5'd16, 32'h0000_1040, 16'd24, 1'b0};
        vecs[1] = '{32'h0000_0FF0, 16'd16,  7'd64, 5'd4,  32'h0000_1000, 16'd12, 1'b0};
        vecs[2] = '{32'h0000_0FFC, 16'd100, 7'd64, 5'd1,  32'h0000_1000, 16'd99, 1'b0};
        vecs[3] = '{32'h0000_2000, 16'd3,   7'd64, 5'd3,  32'h0000_200C, 16'd0,  1'b1};
        vecs[4] = '{32'h0000_2FC0, 16'd20,  7'd16, 5'd16, 32'h0000_3000, 16'd4,  1'b0};
        vecs[5] = '{32'h0000_3F00, 16'd5,   7'd5,  5'd5,  32'h0000_3F14, 16'd0,  1'b1};
        vecs[6] = '{32'hFFFF_FFF8, 16'd16,  7'd64, 5'd2,  32'h0000_0000, 16'd14, 1'b0};
        vecs[7] = '{32'h0000_0400, 16'd16,  7'd16, 5'd16, 32'h0000_0440, 16'd0,  1'b1};

        rst_n = 1'b0; pio_ch = '0; pio_adr_we = 1'b0; pio_len_we = 1'b0; pio_d = '0;
        dff_rval = '0; biu_ack = 1'b0;
        for (int i = 0; i < NCH; i++) cnt[i] = '0;
        tick();
        tick();
        checkOutput("rst_req", 32'(biu_req), 32'd0);
        checkOutput("rst_adr", biu_adr, 32'd0);
        checkOutput("rst_len", 32'(biu_len), 32'd0);
        checkOutput("rst_ch", 32'(biu_ch), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_pio_len", pio_len, 32'd0);
        checkOutput("rst_run", 32'(pio_cst[0]), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single-burst sizing table on channel 0
        for (int v = 0; v < 8; v++) begin
            cnt[0]   = vecs[v].cnt;
            dff_rval = '0;
            applyStimulus(0, vecs[v].adr, 32'(vecs[v].len));
            dff_rval = 4'b0001;
            waitReq($sformatf("vec%0d", v));
            checkOutput($sformatf("vec%0d_adr", v), biu_adr, vecs[v].adr);
            checkOutput($sformatf("vec%0d_len", v), 32'(biu_len), 32'(vecs[v].blen));
            checkOutput($sformatf("vec%0d_ch", v), 32'(biu_ch), 32'd0);
            ackBurst(4'b0001);
            pio_ch = '0;
            checkOutput($sformatf("vec%0d_nadr", v), pio_adr, vecs[v].nadr);
            checkOutput($sformatf("vec%0d_nlen", v), pio_len, 32'(vecs[v].nlen));
            checkOutput($sformatf("vec%0d_done", v), 32'(done), 32'(vecs[v].dn));
            pio_d      = '0;
            pio_len_we = 1'b1;
            tick();
            pio_len_we = 1'b0;
            checkOutput($sformatf("vec%0d_abort", v), 32'(pio_cst[0]), 32'd0);
        end

        // Three-burst transfer with done after the last ack
        doReset();
        cnt[0] = 7'd64;
        applyStimulus(0, 32'h1000, 32'd40);
        dff_rval = 4'b0001;
        for (int b = 0; b < 3; b++) begin
            waitReq($sformatf("t1_b%0d", b));
            checkOutput($sformatf("t1_b%0d_adr", b), biu_adr, 32'h1000 + 32'(b) * 32'h40);
            checkOutput($sformatf("t1_b%0d_len", b), 32'(biu_len), (b == 2) ? 32'd8 : 32'd16);
            ackBurst('0);
            checkOutput($sformatf("t1_b%0d_done", b), 32'(done), (b == 2) ? 32'd1 : 32'd0);
        end
        tick();
        checkOutput("t1_done_gone", 32'(done), 32'd0);
        checkOutput("t1_idle", 32'(biu_req), 32'd0);
        checkOutput("t1_run_clr", 32'(pio_cst[0]), 32'd0);

        // Boundary split: 4 words to 0x1000 then 12 words after it
        doReset();
        cnt[0] = 7'd64;
        applyStimulus(0, 32'h0FF0, 32'd16);
        dff_rval = 4'b0001;
        waitReq("t2_a");
        checkOutput("t2_a_adr", biu_adr, 32'h0FF0);
        checkOutput("t2_a_len", 32'(biu_len), 32'd4);
        ackBurst('0);
        waitReq("t2_b");
        checkOutput("t2_b_adr", biu_adr, 32'h1000);
        checkOutput("t2_b_len", 32'(biu_len), 32'd12);
        ackBurst('0);
        checkOutput("t2_done", 32'(done), 32'd1);

        // Round-robin across four channels
        doReset();
        dff_rval = '0;
        for (int i = 0; i < NCH; i++) begin
            cnt[i] = 7'd64;
            applyStimulus(i, 32'h1_0000 * 32'(i + 1), 32'd32);
        end
        dff_rval = 4'b1111;
        dcount = 0;
        for (int b = 0; b < 8; b++) begin
            ch   = b % NCH;
            base = 32'h1_0000 * 32'(ch + 1) + ((b >= 4) ? 32'h40 : 32'h0);
            waitReq($sformatf("t3_b%0d", b));
            checkOutput($sformatf("t3_b%0d_ch", b), 32'(biu_ch), 32'(ch));
            checkOutput($sformatf("t3_b%0d_adr", b), biu_adr, base);
            checkOutput($sformatf("t3_b%0d_len", b), 32'(biu_len), 32'd16);
            ackBurst('0);
            checkOutput($sformatf("t3_b%0d_done", b), 32'(done), (b >= 4) ? (32'd1 << ch) : 32'd0);
            dcount += $countones(done);
        end
        checkOutput("t3_done_count", 32'(dcount), 32'd4);

        // Request appears one clock after the FIFO level reaches the burst size
        doReset();
        dff_rval = '0;
        cnt[2]   = 7'd15;
        applyStimulus(2, 32'h8000, 32'd16);
        dff_rval = 4'b0100;
        for (int i = 0; i < 4; i++) tick();
        checkOutput("t4_no_req", 32'(biu_req), 32'd0);
        cnt[2] = 7'd16;
        checkOutput("t4_same_cycle", 32'(biu_req), 32'd0);
        tick();
        checkOutput("t4_req", 32'(biu_req), 32'd1);
        checkOutput("t4_len", 32'(biu_len), 32'd16);
        checkOutput("t4_ch", 32'(biu_ch), 32'd2);
        checkOutput("t4_adr", biu_adr, 32'h8000);
        ackBurst(4'b0100);

        // PIO write to the owning channel is ignored, other channels apply
        doReset();
        dff_rval = '0;
        cnt[1]   = 7'd64;
        applyStimulus(1, 32'h4000, 32'd32);
        dff_rval = 4'b0010;
        waitReq("t5");
        checkOutput("t5_ch", 32'(biu_ch), 32'd1);
        pio_ch = 2'd1; pio_d = 32'd5; pio_len_we = 1'b1;
        tick();
        pio_len_we = 1'b0;
        checkOutput("t5_blocked_len", pio_len, 32'd32);
        checkOutput("t5_busy", 32'(pio_cst[1]), 32'd1);
        pio_ch = 2'd0; pio_d = 32'd7; pio_len_we = 1'b1;
        tick();
        pio_len_we = 1'b0;
        checkOutput("t5_other_len", pio_len, 32'd7);
        checkOutput("t5_other_run", 32'(pio_cst[0]), 32'd1);
        checkOutput("t5_hold_req", 32'(biu_req), 32'd1);
        checkOutput("t5_hold_len", 32'(biu_len), 32'd16);
        pio_ch = 2'd0; pio_d = 32'd9; pio_len_we = 1'b1;
        ackBurst(4'b0010);
        pio_len_we = 1'b0;
        checkOutput("t5_ack_write", pio_len, 32'd9);
        pio_ch = 2'd1;
        checkOutput("t5_ch1_len", pio_len, 32'd16);
        checkOutput("t5_ch1_adr", pio_adr, 32'h4040);

        // Reset during an outstanding request
        doReset();
        cnt[0] = 7'd64;
        applyStimulus(0, 32'h1000, 32'd32);
        dff_rval = 4'b0001;
        waitReq("t6");
        rst_n = 1'b0;
        tick();
        checkOutput("t6_req_drop", 32'(biu_req), 32'd0);
        rst_n  = 1'b1;
        pio_ch = 2'd0;
        checkOutput("t6_run", 32'(pio_cst[0]), 32'd0);
        checkOutput("t6_len", pio_len, 32'd0);
        ackBurst('0);
        checkOutput("t6_done", 32'(done), 32'd0);
        checkOutput("t6_len_after_ack", pio_len, 32'd0);
        tick();
        tick();
        checkOutput("t6_no_req", 32'(biu_req), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
